// File: rtl/sm_warp_scheduler.sv
// ---------------------------------------------------------------------------
// sm_warp_scheduler
//
// Per-SM warp scheduler. Tracks the lifecycle state (IDLE/ACTIVE/BAR/DONE)
// and PC of every hardware warp slot. Each cycle it offers one eligible warp
// to the issue stage, picked round-robin. It also handles block-level
// barriers and warp exit, and reports completed warps upstream one at a time.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_valid_i/wid_i/pc_i        launch a new warp into an IDLE slot
//   issue_valid_o/ready_i           issue handshake (combinational offer)
//   issue_wid_o/pc_o                granted warp id and its current PC
//   stall_mask_i                    per-warp stall, 1 = not eligible this cycle
//   bar_valid_i/bar_wid_i           warp arrived at a block barrier
//   exit_valid_i/exit_wid_i         warp executed exit
//   done_valid_o/ready_i/wid_o      completion report handshake
// ---------------------------------------------------------------------------
module sm_warp_scheduler #(
    parameter int NUM_WARP   = 8,
    parameter int DEPTH_WARP = 3,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid_i,
    input  logic [DEPTH_WARP-1:0] start_wid_i,
    input  logic [PC_WIDTH-1:0]   start_pc_i,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [DEPTH_WARP-1:0] issue_wid_o,
    output logic [PC_WIDTH-1:0]   issue_pc_o,
    input  logic [NUM_WARP-1:0]   stall_mask_i,
    input  logic                  bar_valid_i,
    input  logic [DEPTH_WARP-1:0] bar_wid_i,
    input  logic                  exit_valid_i,
    input  logic [DEPTH_WARP-1:0] exit_wid_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic [DEPTH_WARP-1:0] done_wid_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BAR    = 2'd2,
        DONE   = 2'd3
    } warpState_t;

    warpState_t            r_state     [NUM_WARP];
    warpState_t            w_stateNext [NUM_WARP];
    logic [PC_WIDTH-1:0]   r_pc        [NUM_WARP];
    logic [PC_WIDTH-1:0]   w_pcNext    [NUM_WARP];
    logic [DEPTH_WARP-1:0] r_rrPtr;
    logic [DEPTH_WARP-1:0] w_rrPtrNext;

    logic [NUM_WARP-1:0]   w_eligible;
    logic                  w_anyActive;
    logic                  w_anyBar;
    logic                  w_barRelease;
    logic                  w_grantFound;
    logic [DEPTH_WARP-1:0] w_grantWid;
    logic [DEPTH_WARP-1:0] w_probe;
    logic                  w_doneFound;
    logic [DEPTH_WARP-1:0] w_doneWid;
    logic                  w_issueFire;
    logic                  w_doneFire;

    // Per-warp eligibility plus the summary flags used by barrier release.
    // A release happens only once nothing is left ACTIVE, so IDLE and DONE
    // warps never hold a barrier open.
    always_comb begin
        w_eligible  = '0;
        w_anyActive = 1'b0;
        w_anyBar    = 1'b0;
        for (int w = 0; w < NUM_WARP; w++) begin
            w_eligible[w] = (r_state[w] == ACTIVE) && !stall_mask_i[w];
            if (r_state[w] == ACTIVE) w_anyActive = 1'b1;
            if (r_state[w] == BAR)    w_anyBar    = 1'b1;
        end
        w_barRelease = !w_anyActive && w_anyBar;
    end

    // Round-robin grant: first eligible warp at or after the pointer. The
    // probe index is DEPTH_WARP bits wide, so the add wraps modulo NUM_WARP.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantWid   = '0;
        w_probe      = '0;
        for (int k = 0; k < NUM_WARP; k++) begin
            w_probe = r_rrPtr + DEPTH_WARP'(k);
            if (!w_grantFound && w_eligible[w_probe]) begin
                w_grantFound = 1'b1;
                w_grantWid   = w_probe;
            end
        end
    end

    // Completion report picks the lowest-index DONE warp; scanning downward
    // lets the lowest index overwrite any higher one.
    always_comb begin
        w_doneFound = 1'b0;
        w_doneWid   = '0;
        for (int w = NUM_WARP - 1; w >= 0; w--) begin
            if (r_state[w] == DONE) begin
                w_doneFound = 1'b1;
                w_doneWid   = DEPTH_WARP'(w);
            end
        end
        w_issueFire = w_grantFound && issue_ready_i;
        w_doneFire  = w_doneFound && done_ready_i;
    end

    // State register: per-warp state, PCs and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                r_state[w] <= IDLE;
                r_pc[w]    <= '0;
            end
            r_rrPtr <= '0;
        end else begin
            for (int w = 0; w < NUM_WARP; w++) begin
                r_state[w] <= w_stateNext[w];
                r_pc[w]    <= w_pcNext[w];
            end
            r_rrPtr <= w_rrPtrNext;
        end
    end

    // Next-state logic. Within a warp, exit wins over barrier release and
    // barrier arrival; the PC bump on an issue fire is applied regardless of
    // what happens to the state. A start only lands on an IDLE slot, so a
    // slot still being reported as DONE ignores it.
    always_comb begin
        w_rrPtrNext = r_rrPtr;
        if (w_issueFire) w_rrPtrNext = w_grantWid + DEPTH_WARP'(1);
        for (int w = 0; w < NUM_WARP; w++) begin
            w_stateNext[w] = r_state[w];
            w_pcNext[w]    = r_pc[w];
            if (w_issueFire && (w_grantWid == DEPTH_WARP'(w))) begin
                w_pcNext[w] = r_pc[w] + PC_WIDTH'(4);
            end
            case (r_state[w])
                IDLE: begin
                    if (start_valid_i && (start_wid_i == DEPTH_WARP'(w))) begin
                        w_stateNext[w] = ACTIVE;
                        w_pcNext[w]    = start_pc_i;
                    end
                end
                ACTIVE: begin
                    if (exit_valid_i && (exit_wid_i == DEPTH_WARP'(w))) begin
                        w_stateNext[w] = DONE;
                    end else if (bar_valid_i && (bar_wid_i == DEPTH_WARP'(w))) begin
                        w_stateNext[w] = BAR;
                    end
                end
                BAR: begin
                    if (exit_valid_i && (exit_wid_i == DEPTH_WARP'(w))) begin
                        w_stateNext[w] = DONE;
                    end else if (w_barRelease) begin
                        w_stateNext[w] = ACTIVE;
                    end
                end
                DONE: begin
                    if (w_doneFire && (w_doneWid == DEPTH_WARP'(w))) begin
                        w_stateNext[w] = IDLE;
                    end
                end
                default: w_stateNext[w] = IDLE;
            endcase
        end
    end

    // Outputs are driven straight from current state; id and PC read as zero
    // whenever nothing is offered.
    always_comb begin
        issue_valid_o = w_grantFound;
        issue_wid_o   = w_grantWid;
        issue_pc_o    = w_grantFound ? r_pc[w_grantWid] : '0;
        done_valid_o  = w_doneFound;
        done_wid_o    = w_doneWid;
    end

endmodule

// File: tb/tb_sm_warp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sm_warp_scheduler
//
// Self-checking bench for sm_warp_scheduler. Directed scenarios followed by a
// randomized run, all compared every cycle against a behavioural model of the
// warp lifecycle kept in plain arrays.
// ---------------------------------------------------------------------------
module tb_sm_warp_scheduler;

    localparam int N  = 8;
    localparam int DW = 3;
    localparam int PW = 32;

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_BAR    = 2;
    localparam int M_DONE   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic [DW-1:0] start_wid;
    logic [PW-1:0] start_pc;
    logic          issue_valid;
    logic          issue_ready;
    logic [DW-1:0] issue_wid;
    logic [PW-1:0] issue_pc;
    logic [N-1:0]  stall_mask;
    logic          bar_valid;
    logic [DW-1:0] bar_wid;
    logic          exit_valid;
    logic [DW-1:0] exit_wid;
    logic          done_valid;
    logic          done_ready;
    logic [DW-1:0] done_wid;

    int            mState [N];
    logic [PW-1:0] mPc    [N];
    int            mPtr;

    int checks = 0;
    int errors = 0;

    sm_warp_scheduler #(.NUM_WARP(N), .DEPTH_WARP(DW), .PC_WIDTH(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid_i (start_valid),
        .start_wid_i   (start_wid),
        .start_pc_i    (start_pc),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .issue_wid_o   (issue_wid),
        .issue_pc_o    (issue_pc),
        .stall_mask_i  (stall_mask),
        .bar_valid_i   (bar_valid),
        .bar_wid_i     (bar_wid),
        .exit_valid_i  (exit_valid),
        .exit_wid_i    (exit_wid),
        .done_valid_o  (done_valid),
        .done_ready_i  (done_ready),
        .done_wid_o    (done_wid)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int w = 0; w < N; w++) begin
            mState[w] = M_IDLE;
            mPc[w]    = '0;
        end
        mPtr = 0;
    endfunction

    // Scan from the pointer with modulo arithmetic for the first runnable warp.
    function automatic void modelIssue(output bit v, output int wid, output logic [PW-1:0] pc);
        v   = 1'b0;
        wid = 0;
        pc  = '0;
        for (int k = 0; k < N; k++) begin
            int w;
            w = (mPtr + k) % N;
            if (!v && mState[w] == M_ACTIVE && !stall_mask[w]) begin
                v   = 1'b1;
                wid = w;
                pc  = mPc[w];
            end
        end
    endfunction

    function automatic void modelDone(output bit v, output int wid);
        v   = 1'b0;
        wid = 0;
        for (int w = 0; w < N; w++) begin
            if (!v && mState[w] == M_DONE) begin
                v   = 1'b1;
                wid = w;
            end
        end
    endfunction

    task automatic compareAll(input string tag);
        bit            iv, dv;
        int            iw, dw;
        logic [PW-1:0] ipc;
        modelIssue(iv, iw, ipc);
        modelDone(dv, dw);
        checkOutput({tag, ".issueValid"}, 32'(issue_valid), 32'(iv));
        checkOutput({tag, ".issueWid"},   32'(issue_wid),   32'(iw));
        checkOutput({tag, ".issuePc"},    issue_pc,         ipc);
        checkOutput({tag, ".doneValid"},  32'(done_valid),  32'(dv));
        checkOutput({tag, ".doneWid"},    32'(done_wid),    32'(dw));
    endtask

    // Called just after an edge with inputs already driven: check outputs,
    // work out the model's next state from the lifecycle rules, clock once.
    task automatic applyStimulus(input string tag);
        int            nS [N];
        logic [PW-1:0] nP [N];
        int            nPtr;
        bit            iv, dv, anyAct, anyBar;
        int            iw, dw;
        logic [PW-1:0] ipc;
        #1;
        compareAll(tag);
        modelIssue(iv, iw, ipc);
        modelDone(dv, dw);
        nS     = mState;
        nP     = mPc;
        nPtr   = mPtr;
        anyAct = 1'b0;
        anyBar = 1'b0;
        for (int w = 0; w < N; w++) begin
            if (mState[w] == M_ACTIVE) anyAct = 1'b1;
            if (mState[w] == M_BAR)    anyBar = 1'b1;
        end
        if (iv && issue_ready) begin
            nP[iw] = mPc[iw] + 32'd4;
            nPtr   = (iw + 1) % N;
        end
        if (!anyAct && anyBar) begin
            for (int w = 0; w < N; w++) if (mState[w] == M_BAR) nS[w] = M_ACTIVE;
        end
        if (bar_valid && mState[bar_wid] == M_ACTIVE) nS[bar_wid] = M_BAR;
        if (exit_valid && (mState[exit_wid] == M_ACTIVE || mState[exit_wid] == M_BAR))
            nS[exit_wid] = M_DONE;
        if (dv && done_ready) nS[dw] = M_IDLE;
        if (start_valid && mState[start_wid] == M_IDLE) begin
            nS[start_wid] = M_ACTIVE;
            nP[start_wid] = start_pc;
        end
        @(posedge clk);
        mState = nS;
        mPc    = nP;
        mPtr   = nPtr;
        #1;
    endtask

    task automatic clearInputs();
        start_valid = 1'b0;
        start_wid   = '0;
        start_pc    = '0;
        issue_ready = 1'b0;
        stall_mask  = '0;
        bar_valid   = 1'b0;
        bar_wid     = '0;
        exit_valid  = 1'b0;
        exit_wid    = '0;
        done_ready  = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 1'b0;
        #2;
        modelReset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic startWarp(input int wid, input logic [PW-1:0] pc, input string tag);
        start_valid = 1'b1;
        start_wid   = DW'(wid);
        start_pc    = pc;
        applyStimulus(tag);
        start_valid = 1'b0;
    endtask

    // Directed scenarios followed by a randomized run, all in one linear sequence.
    initial begin
        int            expWid [6];
        logic [PW-1:0] expPc  [6];
        int            w;

        expWid = '{0, 2, 5, 0, 2, 5};
        expPc  = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h204, 32'h304};

        clearInputs();
        rst_n = 1'b0;
        modelReset();
        #12;
        checkOutput("reset.issueValid", 32'(issue_valid), 32'd0);
        checkOutput("reset.doneValid",  32'(done_valid),  32'd0);
        checkOutput("reset.issuePc",    issue_pc,         32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin order across three warps with PC advance.
        startWarp(0, 32'h100, "t1.start");
        startWarp(2, 32'h200, "t1.start");
        startWarp(5, 32'h300, "t1.start");
        issue_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("t1.orderWid", 32'(issue_wid), 32'(expWid[i]));
            checkOutput("t1.orderPc",  issue_pc,       expPc[i]);
            applyStimulus("t1.issue");
        end

        // Held grant under back-pressure, stall skip, pointer advance.
        doReset();
        for (int i = 0; i < 4; i++) startWarp(i, 32'h1000 + 32'(i) * 32'h10, "t2.start");
        repeat (3) applyStimulus("t2.hold");
        #1;
        checkOutput("t2.heldWid", 32'(issue_wid), 32'd0);
        checkOutput("t2.heldPc",  issue_pc,       32'h1000);
        stall_mask = 8'h01;
        applyStimulus("t2.stall");
        issue_ready = 1'b1;
        applyStimulus("t2.fire");
        issue_ready = 1'b0;
        stall_mask  = 8'h00;
        #1;
        checkOutput("t2.ptrWid", 32'(issue_wid), 32'd2);
        applyStimulus("t2.after");

        // Two-warp barrier with one-cycle release.
        doReset();
        startWarp(1, 32'h40, "t3.start");
        startWarp(3, 32'h80, "t3.start");
        bar_valid = 1'b1;
        bar_wid   = 3'd1;
        applyStimulus("t3.bar1");
        bar_wid   = 3'd3;
        applyStimulus("t3.bar3");
        bar_valid = 1'b0;
        #1;
        checkOutput("t3.blocked", 32'(issue_valid), 32'd0);
        applyStimulus("t3.release");
        issue_ready = 1'b1;
        repeat (3) applyStimulus("t3.resume");

        // Exit of the last ACTIVE warp releases the barrier; done back-pressure.
        doReset();
        startWarp(0, 32'h500, "t4.start");
        startWarp(1, 32'h600, "t4.start");
        bar_valid = 1'b1;
        bar_wid   = 3'd1;
        applyStimulus("t4.bar");
        bar_valid  = 1'b0;
        exit_valid = 1'b1;
        exit_wid   = 3'd0;
        applyStimulus("t4.exit");
        exit_valid = 1'b0;
        repeat (2) applyStimulus("t4.doneHeld");
        done_ready = 1'b1;
        applyStimulus("t4.doneFire");
        done_ready = 1'b0;
        #1;
        checkOutput("t4.doneCleared", 32'(done_valid), 32'd0);
        applyStimulus("t4.after");

        // Ordered completion reports and a start colliding with a done fire.
        doReset();
        startWarp(2, 32'h700, "t5.start");
        startWarp(6, 32'h800, "t5.start");
        exit_valid = 1'b1;
        exit_wid   = 3'd6;
        applyStimulus("t5.exit6");
        exit_wid   = 3'd2;
        applyStimulus("t5.exit2");
        exit_valid = 1'b0;
        done_ready = 1'b1;
        #1;
        checkOutput("t5.firstDone", 32'(done_wid), 32'd2);
        startWarp(2, 32'h900, "t5.startIgnored");
        #1;
        checkOutput("t5.secondDone", 32'(done_wid), 32'd6);
        checkOutput("t5.retryNotYet", 32'(issue_valid), 32'd0);
        startWarp(2, 32'h900, "t5.startRetry");
        done_ready  = 1'b0;
        issue_ready = 1'b1;
        #1;
        checkOutput("t5.retryPc", issue_pc, 32'h900);
        applyStimulus("t5.after");

        // Asynchronous reset in the middle of activity.
        doReset();
        startWarp(0, 32'hA00, "t6.start");
        startWarp(1, 32'hB00, "t6.start");
        exit_valid = 1'b1;
        exit_wid   = 3'd1;
        applyStimulus("t6.exit");
        exit_valid = 1'b0;
        #1;
        checkOutput("t6.preDone", 32'(done_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6.asyncIssueValid", 32'(issue_valid), 32'd0);
        checkOutput("t6.asyncIssueWid",   32'(issue_wid),   32'd0);
        checkOutput("t6.asyncIssuePc",    issue_pc,         32'd0);
        checkOutput("t6.asyncDoneValid",  32'(done_valid),  32'd0);
        checkOutput("t6.asyncDoneWid",    32'(done_wid),    32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        issue_ready = 1'b1;
        done_ready  = 1'b1;
        repeat (3) applyStimulus("t6.postReset");

        // Randomized traffic; starts only target slots the model holds IDLE.
        doReset();
        for (int i = 0; i < 400; i++) begin
            clearInputs();
            w = int'($urandom_range(0, N - 1));
            if (mState[w] == M_IDLE && $urandom_range(0, 1) == 1) begin
                start_valid = 1'b1;
                start_wid   = DW'(w);
                start_pc    = $urandom;
            end
            issue_ready = ($urandom_range(0, 3) != 0);
            stall_mask  = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            bar_valid   = ($urandom_range(0, 5) == 0);
            bar_wid     = DW'($urandom_range(0, N - 1));
            exit_valid  = ($urandom_range(0, 9) == 0);
            exit_wid    = DW'($urandom_range(0, N - 1));
            done_ready  = ($urandom_range(0, 1) == 1);
            applyStimulus("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
